// File: rtl/data_sram_axi_bridge_pkg.sv
// rtl/data_sram_axi_bridge_pkg.sv - shared types and constants for the SRAM-like to AXI bridge
package data_sram_axi_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_AR   = 3'd1,
        RD_R    = 3'd2,
        WR_AW_W = 3'd3,
        WR_B    = 3'd4
    } bridge_state_t;

    localparam logic [2:0] AXI_SIZE_B = 3'd0;
    localparam logic [2:0] AXI_SIZE_H = 3'd1;
    localparam logic [2:0] AXI_SIZE_W = 3'd2;

    // Tie-offs applied by the wrapper around this bridge
    localparam logic [3:0] AXI_ID    = 4'd0;
    localparam logic [7:0] AXI_LEN   = 8'd0;
    localparam logic [1:0] AXI_BURST = 2'b01;

    localparam logic RstEnable = 1'b0;

endpackage

// File: rtl/data_sram_axi_bridge_size_enc.sv
// rtl/data_sram_axi_bridge_size_enc.sv - byte-select to AXI transfer size encoder
module axi_size_enc
    import data_sram_axi_bridge_pkg::*;
(
    input  logic [3:0] select,
    output logic [2:0] size
);

    // Non-contiguous patterns are never issued upstream; treat them as a word.
    always_comb begin
        size = AXI_SIZE_W;
        case (select)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size = AXI_SIZE_B;
            4'b0011, 4'b1100:                   size = AXI_SIZE_H;
            default:                            size = AXI_SIZE_W;
        endcase
    end

endmodule

// File: rtl/data_sram_axi_bridge.sv
// rtl/data_sram_axi_bridge.sv - single-outstanding SRAM-like to single-beat AXI4 bridge
module data_sram_axi_bridge
    import data_sram_axi_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req,
    input  logic                  wr,
    input  logic [3:0]            select,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic                  addr_ok,
    output logic                  data_ok,
    output logic [DATA_W-1:0]     rdata,

    output logic [ADDR_W-1:0]     araddr,
    output logic [2:0]            arsize,
    output logic                  arvalid,
    input  logic                  arready,

    input  logic [DATA_W-1:0]     rdata_axi,
    input  logic                  rvalid,
    output logic                  rready,

    output logic [ADDR_W-1:0]     awaddr,
    output logic [2:0]            awsize,
    output logic                  awvalid,
    input  logic                  awready,

    output logic [DATA_W-1:0]     wdata_axi,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wvalid,
    input  logic                  wready,

    input  logic                  bvalid,
    output logic                  bready
);

    bridge_state_t state;
    logic [2:0]    req_size;
    logic          aw_done;
    logic          w_done;
    logic          aw_hs;
    logic          w_hs;

    axi_size_enc u_size_enc (
        .select (select),
        .size   (req_size)
    );

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    // Every output is registered so addr_ok cannot loop back into upstream req.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state     <= IDLE;
            addr_ok   <= 1'b0;
            data_ok   <= 1'b0;
            rdata     <= '0;
            araddr    <= '0;
            arsize    <= '0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            awaddr    <= '0;
            awsize    <= '0;
            awvalid   <= 1'b0;
            wdata_axi <= '0;
            wstrb     <= '0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
        end else begin
            addr_ok <= 1'b0;
            data_ok <= 1'b0;

            case (state)
                IDLE: begin
                    if (req) begin
                        addr_ok <= 1'b1;
                        if (wr) begin
                            awaddr    <= addr;
                            awsize    <= req_size;
                            wdata_axi <= wdata;
                            wstrb     <= select;
                            awvalid   <= 1'b1;
                            wvalid    <= 1'b1;
                            aw_done   <= 1'b0;
                            w_done    <= 1'b0;
                            state     <= WR_AW_W;
                        end else begin
                            araddr  <= addr;
                            arsize  <= req_size;
                            arvalid <= 1'b1;
                            state   <= RD_AR;
                        end
                    end
                end

                RD_AR: begin
                    if (arvalid && arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RD_R;
                    end
                end

                RD_R: begin
                    if (rvalid) begin
                        rready  <= 1'b0;
                        rdata   <= rdata_axi;
                        data_ok <= 1'b1;
                        state   <= IDLE;
                    end
                end

                WR_AW_W: begin
                    if (aw_hs) begin
                        awvalid <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid <= 1'b0;
                        w_done <= 1'b1;
                    end
                    // The two channels may complete in either order or together.
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        bready <= 1'b1;
                        state  <= WR_B;
                    end
                end

                WR_B: begin
                    if (bvalid) begin
                        bready  <= 1'b0;
                        data_ok <= 1'b1;
                        state   <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_sram_axi_bridge.sv
// tb/tb_data_sram_axi_bridge.sv - randomized self-checking bench for data_sram_axi_bridge
module tb_data_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, wr;
    logic [3:0]  select;
    logic [31:0] addr, wdata;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid, arready;
    logic [31:0] rdata_axi;
    logic        rvalid, rready;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid, awready;
    logic [31:0] wdata_axi;
    logic [3:0]  wstrb;
    logic        wvalid, wready;
    logic        bvalid, bready;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [31:0] last_rdata = 32'd0;
    logic [3:0]  legal_sel [7] = '{4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

    always #5 clk = ~clk;

    data_sram_axi_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .wr        (wr),
        .select    (select),
        .addr      (addr),
        .wdata     (wdata),
        .addr_ok   (addr_ok),
        .data_ok   (data_ok),
        .rdata     (rdata),
        .araddr    (araddr),
        .arsize    (arsize),
        .arvalid   (arvalid),
        .arready   (arready),
        .rdata_axi (rdata_axi),
        .rvalid    (rvalid),
        .rready    (rready),
        .awaddr    (awaddr),
        .awsize    (awsize),
        .awvalid   (awvalid),
        .awready   (awready),
        .wdata_axi (wdata_axi),
        .wstrb     (wstrb),
        .wvalid    (wvalid),
        .wready    (wready),
        .bvalid    (bvalid),
        .bready    (bready)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] exp_size(input logic [3:0] sel);
        if ($countones(sel) == 1) return 3'd0;
        if (sel == 4'b0011 || sel == 4'b1100) return 3'd1;
        return 3'd2;
    endfunction

    // Issues one request and plays the AXI slave with the given stall counts:
    // ad = address-channel ready delay, dd = W ready delay (write) or rvalid delay (read),
    // bd = bvalid delay. Returns on the negedge of the data_ok cycle.
    task automatic run_txn(input logic w, input logic [3:0] sel, input logic [31:0] a,
                           input logic [31:0] d, input int ad, input int dd, input int bd,
                           input logic [31:0] rd, input bit hold);
        int cyc = 0, aok_n = 0, aok_cyc = -1, dok_n = 0;
        int av_n = 0, dv_n = 0, r_n = 0, b_n = 0, br_n = 0;
        bit a_hs = 0, d_hs = 0, fin_hs = 0, a_done = 0, d_done = 0, finished = 0;
        bit pay_err = 0, stab_err = 0, ord_err = 0;
        int exp_done;
        logic [2:0] sz;
        sz = exp_size(sel);
        exp_done = w ? 3 + ((ad > dd) ? ad : dd) + bd : 3 + ad + dd;
        req = 1'b1; wr = w; select = sel; addr = a; wdata = d;
        while (!finished && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (addr_ok) begin aok_n++; if (aok_cyc < 0) aok_cyc = cyc; end
            if (data_ok) dok_n++;
            if (cyc == 1) begin
                check_eq("first_valid", {30'd0, (w ? awvalid : arvalid), (w ? wvalid : arvalid)}, 32'd3);
                if (!hold) req = 1'b0;
            end
            if (a_hs) a_done = 1;
            if (d_hs) d_done = 1;
            a_hs = 0; d_hs = 0;
            if (fin_hs) begin
                finished = 1;
                req = 1'b0;
                arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
                check_eq("data_ok_cycle", cyc, exp_done);
                check_eq("data_ok_now", {31'd0, data_ok}, 32'd1);
                if (!w) last_rdata = rd;
                check_eq("rdata", rdata, last_rdata);
                check_eq("idle_outputs", {27'd0, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
            end else if (!w) begin
                if (!a_done) begin
                    if (arvalid) begin
                        if (araddr !== a || arsize !== sz) pay_err = 1;
                        if (rready) ord_err = 1;
                        arready = (av_n >= ad); av_n++;
                        a_hs = arready;
                    end else begin
                        arready = 0;
                        if (av_n > 0) stab_err = 1;
                    end
                end else begin
                    arready = 0;
                    if (arvalid) stab_err = 1;
                    if (rready) dv_n++;
                    rvalid = (r_n >= dd); r_n++;
                    rdata_axi = rvalid ? rd : $urandom;
                    fin_hs = rvalid && rready;
                end
            end else begin
                if (!a_done) begin
                    if (awvalid) begin
                        if (awaddr !== a || awsize !== sz) pay_err = 1;
                        awready = (av_n >= ad); av_n++;
                        a_hs = awready;
                    end else begin
                        awready = 0;
                        if (av_n > 0) stab_err = 1;
                    end
                end else begin
                    awready = 0;
                    if (awvalid) stab_err = 1;
                end
                if (!d_done) begin
                    if (wvalid) begin
                        if (wdata_axi !== d || wstrb !== sel) pay_err = 1;
                        wready = (dv_n >= dd); dv_n++;
                        d_hs = wready;
                    end else begin
                        wready = 0;
                        if (dv_n > 0) stab_err = 1;
                    end
                end else begin
                    wready = 0;
                    if (wvalid) stab_err = 1;
                end
                if (a_done && d_done) begin
                    if (bready) br_n++;
                    bvalid = (b_n >= bd); b_n++;
                    fin_hs = bvalid && bready;
                end else if (bready) begin
                    ord_err = 1;
                end
            end
        end
        check_eq("txn_complete", {31'd0, finished}, 32'd1);
        check_eq("addr_ok_count", aok_n, 1);
        check_eq("addr_ok_cycle", aok_cyc, 1);
        check_eq("data_ok_count", dok_n, 1);
        check_eq("payload_stable", {31'd0, pay_err}, 32'd0);
        check_eq("valid_held", {31'd0, stab_err}, 32'd0);
        check_eq("channel_order", {31'd0, ord_err}, 32'd0);
        check_eq("addr_valid_cycles", av_n, ad + 1);
        check_eq("data_ch_cycles", dv_n, dd + 1);
        if (w) check_eq("bready_cycles", br_n, bd + 1);
    endtask

    initial begin
        rst = 1'b0; req = 0; wr = 0; select = 0; addr = 0; wdata = 0;
        arready = 0; rdata_axi = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        repeat (2) @(negedge clk);
        check_eq("reset_ctrl", {25'd0, addr_ok, data_ok, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
        check_eq("reset_rdata", rdata, 32'd0);
        check_eq("reset_addr", araddr | awaddr | wdata_axi, 32'd0);
        check_eq("reset_size_strb", {22'd0, arsize, awsize, wstrb}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        run_txn(1'b0, 4'b1111, 32'h1FC0_0004, 32'h0, 0, 0, 0, 32'hDEAD_BEEF, 1'b0);
        check_eq("min_read_rdata", rdata, 32'hDEAD_BEEF);
        @(negedge clk);
        run_txn(1'b1, 4'b0100, 32'h8000_0002, 32'h00AB_0000, 3, 0, 0, 32'h0, 1'b0);
        run_txn(1'b1, 4'b1111, 32'h8000_0010, 32'h1234_5678, 0, 0, 5, 32'h0, 1'b1);
        run_txn(1'b0, 4'b0011, 32'h0000_0102, 32'h0, 4, 0, 0, 32'hCAFE_F00D, 1'b0);
        // back-to-back: the next request is presented on the data_ok cycle
        run_txn(1'b0, 4'b1000, 32'h0000_0203, 32'h0, 0, 1, 0, 32'h5A5A_A5A5, 1'b0);
        run_txn(1'b1, 4'b1100, 32'h0000_0302, 32'hFFFF_0000, 1, 2, 1, 32'h0, 1'b0);

        // reset while waiting in RD_R
        req = 1'b1; wr = 1'b0; select = 4'hF; addr = 32'h0000_1000;
        @(negedge clk);
        req = 1'b0; arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        check_eq("rd_r_reached", {31'd0, rready}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check_eq("midrst_ctrl", {25'd0, addr_ok, data_ok, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
        check_eq("midrst_rdata", rdata, 32'd0);
        last_rdata = 32'd0;
        @(negedge clk);

        for (int i = 0; i < 60; i++) begin
            logic        w_r;
            logic [3:0]  s_r;
            logic [31:0] rd_r;
            w_r  = 1'($urandom_range(0, 1));
            s_r  = legal_sel[$urandom_range(0, 6)];
            rd_r = $urandom | 32'h1;
            run_txn(w_r, s_r, $urandom, $urandom, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 4)), rd_r, ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
